arith_fptoint_pipe: RTL and testbench



---
 rtl/arith_fp_pkg.sv | 24 ++
 rtl/arith_fp_unpack.sv | 39 +++
 rtl/arith_fptoint_pipe.sv | 166 ++++++++++++++++
 tb/tb_arith_fptoint_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_fp_pkg.sv
// Shared types and helpers for the floating-point arithmetic blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arith_fp_pkg;

  // Operand classes produced by the unpack stage
  typedef enum logic [1:0] {
    FP_ZERO_SUB,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Bit positions inside the 3-bit status flag vector
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  // Exponent bias for an IEEE-754-style format with exp_width exponent bits
  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/arith_fp_unpack.sv
// Splits an FP operand into sign/fraction, classifies it and removes the exponent bias.
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module arith_fp_unpack
  import arith_fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  localparam int IN_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [IN_WIDTH-1:0]     fp_data,
  output logic                    sign,
  output logic [MAN_WIDTH-1:0]    frac,
  output fp_class_e               fp_class,
  output logic signed [EXP_WIDTH:0] exp_unb
);

  localparam int BIAS = fp_bias(EXP_WIDTH);

  logic [EXP_WIDTH-1:0] exp_field;

  assign sign      = fp_data[IN_WIDTH-1];
  assign exp_field = fp_data[MAN_WIDTH +: EXP_WIDTH];
  assign frac      = fp_data[MAN_WIDTH-1:0];

  // One extra bit keeps the unbiased exponent signed over the full field range
  assign exp_unb = $signed({1'b0, exp_field}) - $signed((EXP_WIDTH+1)'(BIAS));

  // Classify from the exponent field; an all-zero field covers both zero and subnormals
  always_comb begin
    fp_class = FP_NORMAL;
    if (exp_field == '1) begin
      fp_class = (frac != '0) ? FP_NAN : FP_INF;
    end else if (exp_field == '0) begin
      fp_class = FP_ZERO_SUB;
    end
  end

endmodule

// File: rtl/arith_fptoint_pipe.sv
// FP to signed/unsigned integer converter, round toward zero, saturating, with status flags.
// Latency: 2 cycles (S1 unpack/classify, S2 shift/saturate), throughput 1 per cycle.
// Backpressure: combinational ready chain from result_ready; a stalled stage holds its data.
module arith_fptoint_pipe
  import arith_fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int OUT_WIDTH = 32,
  localparam int IN_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [IN_WIDTH-1:0]  a_data,
  input  logic                 a_signed,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [OUT_WIDTH-1:0] result_data,
  output logic [2:0]           result_flags
);

  // Magnitude carries one bit beyond the result so the signed negative limit is representable
  localparam int MW = OUT_WIDTH + 1;
  // Shifter width holds the full significand plus any left shift that stays in range
  localparam int WW = MAN_WIDTH + OUT_WIDTH + 1;
  localparam logic [MW-1:0] LIM_POS = (MW'(1) << (OUT_WIDTH - 1)) - MW'(1);
  localparam logic [MW-1:0] LIM_NEG = MW'(1) << (OUT_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                     v1, v2, ready1, ready2;
  logic                     u_sign;
  logic [MAN_WIDTH-1:0]     u_frac;
  fp_class_e                u_class;
  logic signed [EXP_WIDTH:0] u_exp;

  logic                     s1_sign, s1_signed;
  logic [MAN_WIDTH-1:0]     s1_frac;
  fp_class_e                s1_class;
  logic signed [EXP_WIDTH:0] s1_exp;

  logic [OUT_WIDTH-1:0]     cv_data;
  logic [2:0]               cv_flags;
  logic [MW-1:0]            mag;
  logic [WW-1:0]            m_ext;
  logic                     lost, big;
  int                       e_int, rsh;

  assign ready2       = !v2 || result_ready;
  assign ready1       = !v1 || ready2;
  assign a_ready      = ready1;
  assign result_valid = v2;

  arith_fp_unpack #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_unpack (
    .fp_data  (a_data),
    .sign     (u_sign),
    .frac     (u_frac),
    .fp_class (u_class),
    .exp_unb  (u_exp)
  );

  // S1: capture the unpacked operand and mode on accept, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_sign   <= 1'b0;
      s1_signed <= 1'b0;
      s1_frac   <= '0;
      s1_class  <= FP_ZERO_SUB;
      s1_exp    <= '0;
    end else begin
      if (ready1) v1 <= a_valid;
      if (a_valid && ready1) begin
        s1_sign   <= u_sign;
        s1_signed <= a_signed;
        s1_frac   <= u_frac;
        s1_class  <= u_class;
        s1_exp    <= u_exp;
      end
    end
  end

  // Shift the significand to an integer magnitude, then saturate by sign and mode
  always_comb begin
    cv_data  = '0;
    cv_flags = '0;
    mag      = '0;
    lost     = 1'b0;
    big      = 1'b0;
    rsh      = 0;
    e_int    = int'(s1_exp);
    m_ext    = WW'({1'b1, s1_frac});
    if (s1_class == FP_INF) begin
      big = 1'b1;
    end else if (s1_class == FP_NORMAL) begin
      if (e_int < 0) begin
        lost = 1'b1;
      end else if (e_int >= OUT_WIDTH) begin
        big = 1'b1;
      end else if (e_int < MAN_WIDTH) begin
        rsh  = MAN_WIDTH - e_int;
        mag  = MW'(m_ext >> rsh);
        lost = |(m_ext & ((WW'(1) << rsh) - WW'(1)));
      end else begin
        mag = MW'(m_ext << (e_int - MAN_WIDTH));
      end
    end
    case (s1_class)
      FP_NAN:      cv_flags[FLAG_INVALID] = 1'b1;
      FP_ZERO_SUB: cv_flags[FLAG_INEXACT] = |s1_frac;
      default: begin
        if (s1_signed && !s1_sign) begin
          if (big || mag > LIM_POS) begin
            cv_data = SAT_POS;
            cv_flags[FLAG_OVERFLOW] = 1'b1;
          end else begin
            cv_data = OUT_WIDTH'(mag);
            cv_flags[FLAG_INEXACT] = lost;
          end
        end else if (s1_signed) begin
          if (big || mag > LIM_NEG) begin
            cv_data = SAT_NEG;
            cv_flags[FLAG_OVERFLOW] = 1'b1;
          end else begin
            cv_data = OUT_WIDTH'(MW'(0) - mag);
            cv_flags[FLAG_INEXACT] = lost;
          end
        end else if (!s1_sign) begin
          // in-range exponents never exceed the unsigned maximum
          if (big) begin
            cv_data = '1;
            cv_flags[FLAG_OVERFLOW] = 1'b1;
          end else begin
            cv_data = OUT_WIDTH'(mag);
            cv_flags[FLAG_INEXACT] = lost;
          end
        end else begin
          // negative into unsigned: only values that truncate to zero are legal
          if (big || mag != '0) cv_flags[FLAG_INVALID] = 1'b1;
          else                  cv_flags[FLAG_INEXACT] = lost;
        end
      end
    endcase
  end

  // S2: register the converted result; outputs stay frozen while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2           <= 1'b0;
      result_data  <= '0;
      result_flags <= '0;
    end else begin
      if (ready2) v2 <= v1;
      if (v1 && ready2) begin
        result_data  <= cv_data;
        result_flags <= cv_flags;
      end
    end
  end

endmodule

// File: tb/tb_arith_fptoint_pipe.sv
// Directed-vector and streaming bench for arith_fptoint_pipe in f32, f64 and f16 configurations.
// Latency: checks results exactly 2 cycles after accept.
// Backpressure: exercises result_ready stalls and asynchronous reset mid-flight.
module tb_arith_fptoint_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // f32 -> 32-bit instance
  logic        a_valid32 = 0, a_ready32, a_signed32 = 0, result_valid32, result_ready32 = 1;
  logic [31:0] a_data32 = 0, result_data32;
  logic [2:0]  result_flags32;
  // f64 -> 64-bit instance
  logic        a_valid64 = 0, a_ready64, a_signed64 = 0, result_valid64, result_ready64 = 1;
  logic [63:0] a_data64 = 0, result_data64;
  logic [2:0]  result_flags64;
  // f16 -> 8-bit instance
  logic        a_valid16 = 0, a_ready16, a_signed16 = 0, result_valid16, result_ready16 = 1;
  logic [15:0] a_data16 = 0;
  logic [7:0]  result_data16;
  logic [2:0]  result_flags16;

  arith_fptoint_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(23), .OUT_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid32), .a_ready(a_ready32), .a_data(a_data32),
    .a_signed(a_signed32), .result_valid(result_valid32), .result_ready(result_ready32),
    .result_data(result_data32), .result_flags(result_flags32));

  arith_fptoint_pipe #(.EXP_WIDTH(11), .MAN_WIDTH(52), .OUT_WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid64), .a_ready(a_ready64), .a_data(a_data64),
    .a_signed(a_signed64), .result_valid(result_valid64), .result_ready(result_ready64),
    .result_data(result_data64), .result_flags(result_flags64));

  arith_fptoint_pipe #(.EXP_WIDTH(5), .MAN_WIDTH(10), .OUT_WIDTH(8)) u16 (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid16), .a_ready(a_ready16), .a_data(a_data16),
    .a_signed(a_signed16), .result_valid(result_valid16), .result_ready(result_ready16),
    .result_data(result_data16), .result_flags(result_flags16));

  typedef struct {
    logic [31:0] a;
    logic        sg;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic on the f32 fields, truncating toward zero
  task automatic model32(input logic [31:0] a, input logic sg, output logic [31:0] r, output logic [2:0] f);
    logic        s;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [63:0] m, full;
    logic        lo, ovr;
    int          e;
    s = a[31]; ex = a[30:23]; fr = a[22:0];
    r = 0; f = 0; m = 0; lo = 0; ovr = 0;
    if (ex == 8'hFF && fr != 0) begin
      f = 3'b100;
    end else if (ex == 8'h00) begin
      f = {2'b00, (fr != 0)};
    end else begin
      if (ex == 8'hFF) ovr = 1;
      else begin
        e = int'(ex) - 127;
        full = 64'({1'b1, fr});
        if (e < 0) lo = 1;
        else if (e > 40) ovr = 1;
        else if (e >= 23) m = full << (e - 23);
        else begin
          m  = full >> (23 - e);
          lo = (full % (64'd1 << (23 - e))) != 0;
        end
      end
      if (sg && !s) begin
        if (ovr || m > 64'h7FFF_FFFF) begin r = 32'h7FFF_FFFF; f = 3'b010; end
        else begin r = m[31:0]; f = {2'b00, lo}; end
      end else if (sg) begin
        if (ovr || m > 64'h8000_0000) begin r = 32'h8000_0000; f = 3'b010; end
        else begin r = 32'(64'd0 - m); f = {2'b00, lo}; end
      end else if (!s) begin
        if (ovr || m > 64'hFFFF_FFFF) begin r = 32'hFFFF_FFFF; f = 3'b010; end
        else begin r = m[31:0]; f = {2'b00, lo}; end
      end else begin
        if (ovr || m != 0) f = 3'b100;
        else f = {2'b00, lo};
      end
    end
  endtask

  // Single f32 transaction: accept, nothing one cycle later, result on the second cycle
  task automatic run32(input vec_t v, input string nm);
    @(negedge clk);
    a_valid32 = 1; a_data32 = v.a; a_signed32 = v.sg; result_ready32 = 1;
    #1 chk({nm, "_ardy"}, 64'(a_ready32), 64'd1);
    @(posedge clk); #1 a_valid32 = 0;
    @(negedge clk); chk({nm, "_lat1"}, 64'(result_valid32), 64'd0);
    @(negedge clk); chk({nm, "_vld"}, 64'(result_valid32), 64'd1);
    chk({nm, "_data"}, 64'(result_data32), 64'(v.r));
    chk({nm, "_flags"}, 64'(result_flags32), 64'(v.f));
  endtask

  task automatic run64(input logic [63:0] a, input logic sg, input logic [63:0] r, input logic [2:0] f, input string nm);
    @(negedge clk); a_valid64 = 1; a_data64 = a; a_signed64 = sg;
    @(posedge clk); #1 a_valid64 = 0;
    @(negedge clk); @(negedge clk);
    chk({nm, "_vld"}, 64'(result_valid64), 64'd1);
    chk({nm, "_data"}, result_data64, r);
    chk({nm, "_flags"}, 64'(result_flags64), 64'(f));
  endtask

  task automatic run16(input logic [15:0] a, input logic sg, input logic [7:0] r, input logic [2:0] f, input string nm);
    @(negedge clk); a_valid16 = 1; a_data16 = a; a_signed16 = sg;
    @(posedge clk); #1 a_valid16 = 0;
    @(negedge clk); @(negedge clk);
    chk({nm, "_vld"}, 64'(result_valid16), 64'd1);
    chk({nm, "_data"}, 64'(result_data16), 64'(r));
    chk({nm, "_flags"}, 64'(result_flags16), 64'(f));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[15];
    vec_t bp[4];
    logic [34:0] q[$];
    logic [31:0] held, er, ra;
    logic [2:0]  ef;
    logic        have_held, seen, rs;
    int          in_i, out_i, sent, got;

    tv[0]  = '{32'h40490FDB, 1'b1, 32'h0000_0003, 3'b001};
    tv[1]  = '{32'hC2F6E979, 1'b1, 32'hFFFF_FF85, 3'b001};
    tv[2]  = '{32'hCF000000, 1'b1, 32'h8000_0000, 3'b000};
    tv[3]  = '{32'h4F800000, 1'b0, 32'hFFFF_FFFF, 3'b010};
    tv[4]  = '{32'hBF800000, 1'b0, 32'h0000_0000, 3'b100};
    tv[5]  = '{32'hBF000000, 1'b0, 32'h0000_0000, 3'b001};
    tv[6]  = '{32'h7FC00000, 1'b0, 32'h0000_0000, 3'b100};
    tv[7]  = '{32'h00000001, 1'b1, 32'h0000_0000, 3'b001};
    tv[8]  = '{32'h80000000, 1'b1, 32'h0000_0000, 3'b000};
    tv[9]  = '{32'h4F000000, 1'b1, 32'h7FFF_FFFF, 3'b010};
    tv[10] = '{32'hCF000001, 1'b1, 32'h8000_0000, 3'b010};
    tv[11] = '{32'hFF800000, 1'b0, 32'h0000_0000, 3'b100};
    tv[12] = '{32'h7F800000, 1'b0, 32'hFFFF_FFFF, 3'b010};
    tv[13] = '{32'h4F7FFFFF, 1'b0, 32'hFFFF_FF00, 3'b000};
    tv[14] = '{32'h3F800000, 1'b0, 32'h0000_0001, 3'b000};

    bp[0] = '{32'h3F800000, 1'b1, 32'h0000_0001, 3'b000};
    bp[1] = '{32'h40000000, 1'b1, 32'h0000_0002, 3'b000};
    bp[2] = '{32'hC0400000, 1'b1, 32'hFFFF_FFFD, 3'b000};
    bp[3] = '{32'h40800000, 1'b1, 32'h0000_0004, 3'b000};

    // reset state
    #12;
    chk("rst_vld", 64'(result_valid32), 64'd0);
    chk("rst_data", 64'(result_data32), 64'd0);
    chk("rst_flags", 64'(result_flags32), 64'd0);
    @(negedge clk); rst_n = 1;
    #1 chk("rst_ardy_first", 64'(a_ready32), 64'd1);

    // directed f32 table
    for (int i = 0; i < 15; i++) run32(tv[i], $sformatf("vec%0d", i));

    // f64 and f16 configurations
    run64(64'h43E0_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, "f64_2p63_s");
    run64(64'h43E0_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 3'b000, "f64_2p63_u");
    run64(64'hBFF8_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, "f64_m1p5_s");
    run16(16'h7C00, 1'b1, 8'h7F, 3'b010, "f16_pinf_s");
    run16(16'hFC00, 1'b1, 8'h80, 3'b010, "f16_ninf_s");
    run16(16'h5A40, 1'b0, 8'hC8, 3'b000, "f16_200_u");
    run16(16'h5A40, 1'b1, 8'h7F, 3'b010, "f16_200_s");
    run16(16'hD800, 1'b1, 8'h80, 3'b000, "f16_m128_s");

    // back-pressure: result_ready low for 5 cycles while streaming 4 inputs
    in_i = 0; out_i = 0; have_held = 0; held = 0;
    for (int c = 0; c < 40 && out_i < 4; c++) begin
      @(negedge clk);
      a_valid32 = (in_i < 4);
      a_data32 = (in_i < 4) ? bp[in_i].a : 32'h0;
      a_signed32 = 1'b1;
      result_ready32 = (c >= 5);
      #1;
      if (result_valid32 && !result_ready32) begin
        if (have_held) chk("bp_hold", 64'(result_data32), 64'(held));
        else begin held = result_data32; have_held = 1; end
      end
      if (result_valid32 && result_ready32) begin
        chk($sformatf("bp_out%0d", out_i), 64'({result_flags32, result_data32}),
            64'({bp[out_i].f, bp[out_i].r}));
        out_i++;
      end
      if (a_valid32 && a_ready32) in_i++;
      if (c == 4) begin
        chk("bp_accepted", 64'(in_i), 64'd2);
        chk("bp_ardy_low", 64'(a_ready32), 64'd0);
      end
    end
    chk("bp_count", 64'(out_i), 64'd4);
    @(negedge clk); a_valid32 = 0;
    @(negedge clk); chk("bp_no_dup", 64'(result_valid32), 64'd0);

    // randomized streaming at full rate against the reference
    sent = 0; got = 0;
    for (int c = 0; c < 10006; c++) begin
      @(negedge clk);
      result_ready32 = 1;
      a_valid32 = (sent < 10000);
      if (sent < 10000) begin
        ra = $urandom;
        if ($urandom_range(0, 3) != 0) ra[30:23] = 8'($urandom_range(110, 165));
        if ($urandom_range(0, 31) == 0) ra[30:23] = 8'hFF;
        if ($urandom_range(0, 31) == 0) ra[30:23] = 8'h00;
        rs = 1'($urandom_range(0, 1));
        a_data32 = ra; a_signed32 = rs;
      end
      #1;
      if (result_valid32) begin
        if (q.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
        else chk($sformatf("rnd%0d", got), 64'({result_flags32, result_data32}), 64'(q.pop_front()));
        got++;
      end
      if (sent < 10000) begin
        chk("rnd_ardy", 64'(a_ready32), 64'd1);
        if (a_ready32) begin
          model32(a_data32, a_signed32, er, ef);
          q.push_back({ef, er});
          sent++;
        end
      end
    end
    chk("rnd_count", 64'(got), 64'd10000);
    a_valid32 = 0;

    // asynchronous reset while both stages hold data
    @(negedge clk);
    a_valid32 = 1; a_data32 = 32'h3F800000; a_signed32 = 1; result_ready32 = 0;
    @(negedge clk); a_data32 = 32'h40000000;
    @(negedge clk); a_valid32 = 0;
    chk("arst_pre_vld", 64'(result_valid32), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_vld", 64'(result_valid32), 64'd0);
    chk("arst_data", 64'(result_data32), 64'd0);
    chk("arst_flags", 64'(result_flags32), 64'd0);
    @(negedge clk); rst_n = 1; result_ready32 = 1;
    #1 chk("arst_ardy", 64'(a_ready32), 64'd1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (result_valid32) seen = 1;
    end
    chk("arst_no_stale", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
